// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: four-state execute sequencer feeding ALUmodule from an 8x8 register file,
// with a load-immediate path that bypasses the ALU.
module alu_exec_sequencer #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    input  logic [7:0]  alu_out,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        zero_flag,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);
    typedef enum logic [1:0] {IDLE, DISPATCH, EXECUTE, WRITEBACK} state_t;
    state_t      state_q, state_d;
    logic [15:0] instr_q;
    logic [7:0]  result_q;
    logic [7:0]  rf_q [8];
    logic [2:0]  op_q;
    logic [7:0]  in1_q, in2_q;
    logic        zero_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = instr_valid ? (instr[15] ? WRITEBACK : DISPATCH) : IDLE;
            DISPATCH: state_d = EXECUTE;
            EXECUTE:  state_d = WRITEBACK;
            default:  state_d = IDLE;
        endcase
    end
    // The immediate is preloaded into result_q at accept; ALU ops overwrite it in EXECUTE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            zero_q   <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_valid) begin
                instr_q  <= instr;
                result_q <= instr[7:0];
            end
            if (state_q == DISPATCH) begin
                op_q  <= instr_q[14:12];
                in1_q <= rf_q[instr_q[8:6]];
                in2_q <= rf_q[instr_q[5:3]];
            end
            if (state_q == EXECUTE) result_q <= alu_out;
            if (state_q == WRITEBACK) begin
                rf_q[instr_q[11:9]] <= result_q;
                zero_q              <= (result_q == 8'h00);
            end
        end
    end
    assign instr_ready = (state_q == IDLE);
    assign alu_opcode  = op_q;
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign wb_valid    = (state_q == WRITEBACK);
    assign wb_addr     = instr_q[11:9];
    assign wb_data     = result_q;
    assign zero_flag   = zero_q;
    assign dbg_data    = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer: directed plus random instruction streams checked every cycle against
// a transaction-level model of the sequencer and a behavioural ALU.
module tb_alu_exec_sequencer;
    localparam logic [7:0] RV = 8'h3C;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, LS = 3'd4, RS = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_in1, alu_in2, alu_out;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        zero_flag;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            OR_:     return a | b;
            LS:      return a << b;
            RS:      return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_opcode, alu_in1, alu_in2);

    alu_exec_sequencer #(.RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: one in-flight transaction, timed by edges elapsed since its accept edge.
    logic [7:0] mrf [8];
    logic [2:0] m_op;
    logic [7:0] m_in1, m_in2;
    logic       m_zero;
    bit         started = 0;
    bit         p_active = 0, p_ldi = 0;
    logic [2:0] p_op, p_rd, p_rs1, p_rs2;
    logic [7:0] p_res;
    int         age = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        bit rdy;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 8; i++) mrf[i] = RV;
            m_op = 0; m_in1 = 0; m_in2 = 0; m_zero = 0;
            p_active = 0;
            started = 1;
        end else if (started) begin
            rdy = !p_active;
            if (p_active) begin
                age++;
                if (!p_ldi && age == 1) begin
                    m_op = p_op; m_in1 = mrf[p_rs1]; m_in2 = mrf[p_rs2];
                end
                if (!p_ldi && age == 2) p_res = alu_fn(m_op, m_in1, m_in2);
                if (age == (p_ldi ? 1 : 3)) begin
                    mrf[p_rd] = p_res;
                    m_zero = (p_res == 8'h00);
                    p_active = 0;
                end
            end
            if (rdy && instr_valid) begin
                p_active = 1; age = 0;
                p_ldi = instr[15]; p_op = instr[14:12]; p_rd = instr[11:9];
                p_rs1 = instr[8:6]; p_rs2 = instr[5:3]; p_res = instr[7:0];
            end
        end
    end

    logic [7:0] last_wb_data;
    logic [2:0] last_wb_addr;
    int         wb_cnt = 0;
    int         wb_cyc[$];
    bit         prev_wb = 0;

    always @(negedge clk) begin
        if (started && !reset) begin
            bit e_wb;
            e_wb = p_active && age == (p_ldi ? 0 : 2);
            chk("instr_ready", instr_ready, !p_active);
            chk("wb_valid", wb_valid, e_wb);
            chk("alu_opcode", alu_opcode, m_op);
            chk("alu_in1", alu_in1, m_in1);
            chk("alu_in2", alu_in2, m_in2);
            chk("zero_flag", zero_flag, m_zero);
            chk("dbg_data", dbg_data, mrf[dbg_addr]);
            if (wb_valid) begin
                chk("wb_addr", wb_addr, p_rd);
                chk("wb_data", wb_data, p_res);
                chk("wb_single", prev_wb, 0);
                last_wb_data = wb_data; last_wb_addr = wb_addr;
                wb_cnt++; wb_cyc.push_back(cyc);
            end
            prev_wb = wb_valid;
        end else prev_wb = 0;
    end

    function automatic logic [15:0] alu_i(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {1'b1, 3'b000, rd, 1'b0, imm};
    endfunction

    task automatic send(input logic [15:0] w);
        bit ok = 0;
        instr = w; instr_valid = 1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk); ok = instr_ready;
            @(posedge clk); #2;
        end
        instr_valid = 0; instr = 16'($urandom);
        chk("accept", ok, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && p_active; k++) begin
            @(posedge clk); #2;
        end
        chk("idle", p_active, 0);
    endtask

    task automatic peek(input string nm, input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a; #1;
        chk(nm, dbg_data, exp);
    endtask

    initial begin
        logic [2:0] sweep_op [4];
        logic [7:0] sweep_res [4];
        int n0;
        sweep_op = '{AND_, OR_, LS, RS};
        sweep_res = '{8'h00, 8'h07, 8'h14, 8'h01};
        repeat (3) @(posedge clk);
        #2 reset = 0;
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_in2", alu_in2, 0);
        chk("rst_wb", {wb_valid, 5'b0, wb_addr, wb_data}, 0);
        chk("rst_zero", zero_flag, 0);
        peek("rst_rf0", 0, RV);

        send(ldi(1, 8'h05)); send(ldi(2, 8'h02)); send(alu_i(ADD, 3, 1, 2));
        wait_idle();
        chk("add_opcode", alu_opcode, ADD);
        chk("add_in1", alu_in1, 8'h05);
        chk("add_in2", alu_in2, 8'h02);
        chk("add_wb", {5'b0, last_wb_addr, last_wb_data}, {5'b0, 3'd3, 8'h07});
        chk("add_zero", zero_flag, 0);
        peek("add_rf3", 3, 8'h07);

        send(alu_i(SUB, 4, 2, 1)); wait_idle();
        chk("sub_fd", last_wb_data, 8'hFD);
        send(alu_i(SUB, 5, 1, 1)); wait_idle();
        chk("sub_zero_data", last_wb_data, 8'h00);
        chk("sub_zero_flag", zero_flag, 1);
        send(ldi(6, 8'h00)); wait_idle();
        chk("ldi0_zero", zero_flag, 1);
        send(ldi(6, 8'h80)); wait_idle();
        chk("ldi80_zero", zero_flag, 0);

        send(alu_i(ADD, 1, 1, 1)); wait_idle();
        chk("alias_ins", {alu_in1, alu_in2}, 16'h0505);
        peek("alias_rf1", 1, 8'h0A);
        send(alu_i(OR_, 2, 1, 1)); wait_idle();
        chk("alias_or_in1", alu_in1, 8'h0A);
        chk("alias_or_wb", last_wb_data, 8'h0A);

        send(ldi(1, 8'h05)); send(ldi(2, 8'h02));
        wait_idle();
        wb_cyc.delete();
        n0 = wb_cnt;
        send(alu_i(ADD, 3, 1, 2)); send(alu_i(SUB, 4, 1, 2)); send(alu_i(OR_, 5, 1, 2));
        wait_idle();
        chk("b2b_count", 16'(wb_cnt - n0), 3);
        if (wb_cyc.size() == 3) begin
            chk("b2b_gap1", 16'(wb_cyc[1] - wb_cyc[0]), 4);
            chk("b2b_gap2", 16'(wb_cyc[2] - wb_cyc[1]), 4);
        end
        peek("b2b_rf5", 5, 8'h07);

        for (int i = 0; i < 4; i++) begin
            send(alu_i(sweep_op[i], 3, 1, 2)); wait_idle();
            chk("sweep_opcode", alu_opcode, sweep_op[i]);
            chk("sweep_wb", last_wb_data, sweep_res[i]);
        end

        n0 = wb_cnt;
        send(alu_i(ADD, 7, 1, 2));
        @(posedge clk); #2 reset = 1;
        @(posedge clk); #2 reset = 0;
        #1;
        chk("rsx_ready", instr_ready, 1);
        chk("rsx_alu", {alu_opcode, alu_in1, alu_in2}, 0);
        chk("rsx_wb", {wb_valid, 5'b0, wb_addr, wb_data}, 0);
        chk("rsx_zero", zero_flag, 0);
        peek("rsx_rf7", 7, RV);
        repeat (4) @(posedge clk);
        #2;
        chk("rsx_nowb", 16'(wb_cnt - n0), 0);
        peek("rsx_rf7_late", 7, RV);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] w;
            w = ($urandom_range(0, 2) == 0) ? ldi(3'($urandom), 8'($urandom))
                : alu_i(3'($urandom_range(0, 5)), 3'($urandom), 3'($urandom), 3'($urandom));
            dbg_addr = 3'($urandom);
            send(w);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #2 dbg_addr = 3'($urandom);
            end
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_exec_sequencer.md
# alu_exec_sequencer

Multi-cycle execute sequencer for the 8-bit processor, sitting directly upstream of `ALUmodule`. It accepts one 16-bit instruction at a time through a valid/ready handshake and reads two operands from an internal 8x8 register file. It drives `opcode`/`in1`/`in2` into the ALU, captures the ALU `out`, and writes the result back to the register file, updating a zero flag. It also executes load-immediate instructions without using the ALU.

## Interface
- `RESET_VALUE`, default 8'h00: value loaded into every register-file entry on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  upstream offers `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction; high only in IDLE.
- `instr`  in  16  instruction word (format below).
- `alu_opcode`  out  3  registered; to `ALUmodule.opcode`.
- `alu_in1`  out  8  registered; to `ALUmodule.in1`.
- `alu_in2`  out  8  registered; to `ALUmodule.in2`.
- `alu_out`  in  8  from `ALUmodule.out`; combinational result.
- `wb_valid`  out  1  one-cycle pulse; a register write happens at the end of this cycle.
- `wb_addr`  out  3  destination register of the current write.
- `wb_data`  out  8  value being written.
- `zero_flag`  out  1  set when the last written value == 0.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  8  combinational `rf[dbg_addr]`.

## Operation
- Instruction format:
  - `instr[15]`: 0 = ALU op, 1 = LDI.
  - `instr[14:12]`: ALU opcode, passed unmodified to `alu_opcode`. Encodings are those of `ADD`, `SUB`, `AND`, `OR`, `LS`, `RS` in parameters.v.
  - `instr[11:9]`: rd.
  - `instr[8:6]`: rs1.
  - `instr[5:3]`: rs2. For LDI, the immediate is `instr[7:0]`, and the rs fields are ignored.
- FSM states: IDLE, DISPATCH, EXECUTE, WRITEBACK.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr`.
  - Next state: DISPATCH for an ALU op; WRITEBACK with result = imm for LDI.
- DISPATCH: at the end of the cycle, register `alu_opcode`<=op, `alu_in1`<=rf[rs1], `alu_in2`<=rf[rs2]. Next state: EXECUTE.
- EXECUTE: ALU inputs are stable. At the end of the cycle, capture `alu_out` into the result register. Next state: WRITEBACK.
- WRITEBACK:
  - `wb_valid`=1; `wb_addr`=rd; `wb_data`=result.
  - At the end of the cycle: rf[rd]<=result; `zero_flag`<=(result==0).
  - Next state: IDLE.
- `alu_opcode`/`alu_in1`/`alu_in2` hold their last values outside DISPATCH; they are never cleared between instructions.
- Operand read sources:
  - rd == rs1 or rd == rs2: operands are read before the write, so the old value is used.
  - rs1 == rs2: legal; both operands equal.
- All 8 registers are writable; there is no hardwired zero register.
- `dbg_data` reflects rf contents including a write on the cycle after the write edge; it never sees the in-flight `wb_data`.

## Timing
- Reset values:
  - State = IDLE.
  - `instr_ready`=1.
  - `alu_opcode`=0, `alu_in1`=0, `alu_in2`=0.
  - `wb_valid`=0, `wb_addr`=0, `wb_data`=0.
  - `zero_flag`=0.
  - All rf entries = `RESET_VALUE`.
- Accept edge E0 is a rising edge where `instr_valid`&`instr_ready`.
- ALU op: DISPATCH in the cycle after E0; ALU inputs valid after E1; `alu_out` sampled at E2; `wb_valid` high in the cycle E2–E3; rf updated at E3. Throughput: one ALU op per 4 cycles.
- LDI: `wb_valid` high in the cycle E0–E1; rf updated at E1. Throughput: one LDI per 2 cycles.
- `instr_ready` is low in DISPATCH, EXECUTE and WRITEBACK.
- `instr_valid` asserted while not ready is ignored. The instruction is not latched and must be held by upstream until accepted.
- `reset` has priority over everything, in any state:
  - The in-flight instruction is discarded with no rf write.
  - If reset is high during WRITEBACK, the write is suppressed.
- `wb_valid` is never high for more than one consecutive cycle.

## Test plan
- LDI r1,8'h05; LDI r2,8'h02; ADD r3,r1,r2 -> `alu_opcode`=`ADD`, `alu_in1`=5, `alu_in2`=2 after E1; `wb_valid` in cycle 3 with `wb_addr`=3, `wb_data`=8'h07; `zero_flag`=0; `dbg_data`(3)=8'h07.
- With r1=5, r2=2: SUB r4,r2,r1 -> `wb_data`=8'hFD. SUB r5,r1,r1 -> `wb_data`=8'h00 and `zero_flag`=1 after the write edge. LDI r6,8'h00 -> `zero_flag`=1; LDI r6,8'h80 -> `zero_flag`=0.
- Back-to-back: hold `instr_valid` high with 3 queued ALU instructions -> `instr_ready` high exactly once every 4 cycles; 3 `wb_valid` pulses, 4 cycles apart; no instruction lost or duplicated.
- Register aliasing: r1=5; ADD r1,r1,r1 -> `alu_in1`=`alu_in2`=5, rf[1]=8'h0A. A following OR r2,r1,r1 reads 8'h0A.
- Opcode sweep with r1=5, r2=2 through AND, OR, LS, RS -> `alu_opcode` equals `instr[14:12]` each time, and `wb_data` equals the `alu_out` value driven by the model at E2.
- Reset asserted for one cycle during EXECUTE of ADD r7,r1,r2 -> no `wb_valid`; rf[7]=`RESET_VALUE`; `instr_ready`=1 in the cycle after reset; all outputs at their reset values.
